// File: rtl/nor3_arb_pkg.sv
// Shared types and helpers for the three-requester NOR3 round-robin arbiter.
package nor3_arb_pkg;

  localparam int N_REQ = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef logic [1:0]       ptr_t;
  typedef logic [N_REQ-1:0] gnt_t;

  // Modulo-3 addition; a stray pointer value of 3 folds back into range.
  function automatic ptr_t ptr_add(input ptr_t p, input ptr_t k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Pointer value that follows a grant to the given one-hot owner.
  function automatic ptr_t ptr_after(input gnt_t g);
    ptr_t p;
    case (g)
      3'b001:  p = 2'd1;
      3'b010:  p = 2'd2;
      default: p = 2'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/nor3_arb_rr_pick.sv
// Combinational round-robin picker: first set request in order ptr, ptr+1, ptr+2 (mod 3).
module nor3_arb_rr_pick
  import nor3_arb_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [2:0] o_pick,
  output logic       o_valid
);

  always_comb begin
    ptr_t w_idx;
    gnt_t w_cand;
    // NOTE: every combinational output gets a default before any branch,
    // otherwise a path that skips the assignment infers a latch.
    w_idx  = '0;
    w_cand = '0;
    o_pick = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx  = ptr_add(i_ptr, ptr_t'(k));
      w_cand = gnt_t'(3'b001 << w_idx);
      if ((o_pick == '0) && ((i_req & w_cand) != '0)) o_pick = w_cand;
    end
  end

  assign o_valid = |o_pick;

endmodule

// File: rtl/nor3_req_rr_arbiter.sv
// Round-robin arbiter for the three NOR3 inputs with registered NOR output.
// Define NOR3_ARB_HOLD_LIMIT_EN to enable the HOLD_MAX forced-rotation timeout.
module nor3_req_rr_arbiter
  import nor3_arb_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       A1,
  input  logic       A2,
  input  logic       A3,
  output logic [2:0] GNT,
  output logic       ZN,
  inout  wire        VDD,
  inout  wire        VSS
);

  state_t     r_state, w_state_nxt;
  gnt_t       r_gnt, w_gnt_nxt;
  ptr_t       r_ptr, w_ptr_nxt;
  logic       r_zn;

  logic [2:0] w_req;
  logic [2:0] w_pick_mask;
  logic [2:0] w_pick;
  logic       w_pick_valid;
  logic       w_owner_req;

  wire w_unused_supply = VDD ^ VSS;

  assign w_req       = {A3, A2, A1};
  assign w_owner_req = |(w_req & r_gnt);
  // In BUSY the current owner never competes: it either keeps the grant or is releasing it.
  assign w_pick_mask = (r_state == IDLE) ? w_req : (w_req & ~r_gnt);

  nor3_arb_rr_pick u_pick (
    .i_req   (w_pick_mask),
    .i_ptr   (r_ptr),
    .o_pick  (w_pick),
    .o_valid (w_pick_valid)
  );

`ifdef NOR3_ARB_HOLD_LIMIT_EN
  localparam logic [CNT_W-1:0] L_HOLD_MAX  = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] L_HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_timeout;

  assign w_timeout = (r_cnt == L_HOLD_LAST);
`else
  wire [CNT_W-1:0] w_unused_hold = CNT_W'(HOLD_MAX);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
`ifdef NOR3_ARB_HOLD_LIMIT_EN
    w_cnt_nxt   = r_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_gnt_nxt   = w_pick;
          w_ptr_nxt   = ptr_after(w_pick);
          w_state_nxt = BUSY;
`ifdef NOR3_ARB_HOLD_LIMIT_EN
          w_cnt_nxt   = '0;
`endif
        end
      end
      BUSY: begin
        if (!w_owner_req) begin
          if (w_pick_valid) begin
            w_gnt_nxt = w_pick;
            w_ptr_nxt = ptr_after(w_pick);
          end else begin
            w_gnt_nxt   = '0;
            w_state_nxt = IDLE;
          end
`ifdef NOR3_ARB_HOLD_LIMIT_EN
          w_cnt_nxt = '0;
        end else if (w_timeout) begin
          // A lone owner keeps the grant; only the hold window restarts.
          if (w_pick_valid) begin
            w_gnt_nxt = w_pick;
            w_ptr_nxt = ptr_after(w_pick);
          end
          w_cnt_nxt = '0;
        end else if (r_cnt != L_HOLD_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (RST) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_zn    <= 1'b1;
`ifdef NOR3_ARB_HOLD_LIMIT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_zn    <= ~|w_req;
`ifdef NOR3_ARB_HOLD_LIMIT_EN
      r_cnt   <= w_cnt_nxt;
`endif
    end
  end

  assign GNT = r_gnt;
  assign ZN  = r_zn;

endmodule
